// File: rtl/jam_job_ctrl.sv
// jam_job_ctrl: job sequencer for the JAM assignment search engine.
// Loads an NxN cost table from a host stream, serves the engine's
// combinational cost lookups, runs the engine with a cycle budget and
// returns MinCost/MatchCount/cycle count over a valid/ready handshake.
module jam_job_ctrl #(
  parameter int unsigned N       = 8,
  parameter int unsigned COST_W  = 7,
  parameter logic [23:0] TIMEOUT = 24'd400000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COST_W-1:0]    in_data,
  input  logic                 abort,
  output logic                 eng_rst,
  input  logic [$clog2(N)-1:0] eng_W,
  input  logic [$clog2(N)-1:0] eng_J,
  output logic [COST_W-1:0]    eng_cost,
  input  logic                 eng_valid,
  input  logic [9:0]           eng_mincost,
  input  logic [3:0]           eng_matchcount,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [9:0]           res_mincost,
  output logic [3:0]           res_matchcount,
  output logic [23:0]          res_cycles,
  output logic                 err_timeout,
  output logic                 busy
);

  localparam int unsigned AW      = $clog2(N);
  localparam int unsigned IW      = 2 * AW;
  localparam int unsigned ENTRIES = N * N;
  localparam logic [IW-1:0] LAST  = IW'(ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_RUN,
    S_RESULT
  } state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic                kick_cnt;
  logic [23:0]         cnt;
  logic [23:0]         cnt_inc;
  logic                accept;
  logic [COST_W-1:0]   tbl [ENTRIES];

  // Status/handshake decodes of the registered state.
  always_comb begin
    in_ready = ((state == S_IDLE) || (state == S_LOAD)) && !abort;
    accept   = in_valid && in_ready;
    eng_rst  = (state != S_RUN);
    busy     = (state != S_IDLE);
    eng_cost = tbl[{eng_W, eng_J}];
    cnt_inc  = (cnt == '1) ? cnt : cnt + 24'd1;
  end

  // Job sequencer: load, engine kick, run with budget, result handshake.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= S_IDLE;
      idx            <= '0;
      kick_cnt       <= 1'b0;
      cnt            <= '0;
      res_valid      <= 1'b0;
      res_mincost    <= '0;
      res_matchcount <= '0;
      res_cycles     <= '0;
      err_timeout    <= 1'b0;
      tbl            <= '{default: '0};
    end else if (abort && (state != S_IDLE)) begin
      state     <= S_IDLE;
      idx       <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            tbl[0] <= in_data;
            idx    <= IW'(1);
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            tbl[idx] <= in_data;
            if (idx == LAST) begin
              idx      <= '0;
              kick_cnt <= 1'b0;
              state    <= S_KICK;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_KICK: begin
          cnt         <= '0;
          err_timeout <= 1'b0;
          kick_cnt    <= 1'b1;
          if (kick_cnt) state <= S_RUN;
        end
        S_RUN: begin
          if (eng_valid) begin
            res_mincost    <= eng_mincost;
            res_matchcount <= eng_matchcount;
            res_cycles     <= cnt;
            res_valid      <= 1'b1;
            state          <= S_RESULT;
          end else if (cnt_inc == (TIMEOUT - 24'd1)) begin
            // Budget hit on the cycle the count reaches TIMEOUT-1.
            res_mincost    <= '1;
            res_matchcount <= '0;
            res_cycles     <= cnt_inc;
            err_timeout    <= 1'b1;
            res_valid      <= 1'b1;
            state          <= S_RESULT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_job_ctrl.sv
// Directed bench for jam_job_ctrl: main instance with default budget plus a
// second instance with TIMEOUT=50 driven through the same host signals.
module tb_jam_job_ctrl;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic       sel;
  logic       in_valid, abort, res_ready;
  logic [6:0] in_data;
  int         mode;
  logic [2:0] rd_w, rd_j;

  // main instance
  logic       m_in_valid, m_in_ready, m_abort, m_eng_rst, m_eng_valid;
  logic [2:0] m_eng_W, m_eng_J;
  logic [6:0] m_eng_cost;
  logic [9:0] m_eng_mincost, m_res_mincost;
  logic [3:0] m_eng_matchcount, m_res_matchcount;
  logic       m_res_valid, m_res_ready, m_err_timeout, m_busy;
  logic [23:0] m_res_cycles;

  // timeout instance
  logic       t_in_valid, t_in_ready, t_abort, t_eng_rst;
  logic [6:0] t_eng_cost;
  logic [9:0] t_res_mincost;
  logic [3:0] t_res_matchcount;
  logic       t_res_valid, t_res_ready, t_err_timeout, t_busy;
  logic [23:0] t_res_cycles;

  assign m_in_valid  = in_valid & ~sel;
  assign t_in_valid  = in_valid & sel;
  assign m_abort     = abort & ~sel;
  assign t_abort     = abort & sel;
  assign m_res_ready = res_ready & ~sel;
  assign t_res_ready = res_ready & sel;

  jam_job_ctrl u_dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .abort(m_abort), .eng_rst(m_eng_rst),
    .eng_W(m_eng_W), .eng_J(m_eng_J), .eng_cost(m_eng_cost),
    .eng_valid(m_eng_valid), .eng_mincost(m_eng_mincost),
    .eng_matchcount(m_eng_matchcount), .res_valid(m_res_valid),
    .res_ready(m_res_ready), .res_mincost(m_res_mincost),
    .res_matchcount(m_res_matchcount), .res_cycles(m_res_cycles),
    .err_timeout(m_err_timeout), .busy(m_busy)
  );

  jam_job_ctrl #(.TIMEOUT(24'd50)) u_dut_to (
    .CLK(CLK), .RST_N(RST_N), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_data(in_data), .abort(t_abort), .eng_rst(t_eng_rst),
    .eng_W(3'd0), .eng_J(3'd0), .eng_cost(t_eng_cost),
    .eng_valid(1'b0), .eng_mincost(10'd0), .eng_matchcount(4'd0),
    .res_valid(t_res_valid), .res_ready(t_res_ready),
    .res_mincost(t_res_mincost), .res_matchcount(t_res_matchcount),
    .res_cycles(t_res_cycles), .err_timeout(t_err_timeout), .busy(t_busy)
  );

  // Engine model: mode 0 scans the table (sum of row minima, matchcount 1
  // when the row minima fall in distinct columns); mode 1 reports 321/3
  // after 100 run cycles; mode 2 never finishes and lets the bench drive W/J.
  logic [7:0] ecnt;
  logic       ev;
  logic [9:0] sum;
  logic [7:0] mask;
  logic [6:0] rowmin, fmin;
  logic [2:0] rowarg, farg;

  assign m_eng_W          = (mode == 2) ? rd_w : ecnt[5:3];
  assign m_eng_J          = (mode == 2) ? rd_j : ecnt[2:0];
  assign m_eng_valid      = ev;
  assign m_eng_mincost    = (mode == 1) ? 10'd321 : sum;
  assign m_eng_matchcount = (mode == 1) ? 4'd3 : ((mask == 8'hFF) ? 4'd1 : 4'd0);
  assign fmin = (m_eng_cost < rowmin) ? m_eng_cost : rowmin;
  assign farg = (m_eng_cost < rowmin) ? 3'd7 : rowarg;

  always_ff @(posedge CLK) begin
    if (m_eng_rst) begin
      ecnt <= '0; ev <= 1'b0; sum <= '0; mask <= '0; rowmin <= '0; rowarg <= '0;
    end else if (!ev) begin
      ecnt <= ecnt + 8'd1;
      if (mode == 0) begin
        if (ecnt[2:0] == 3'd0) begin
          rowmin <= m_eng_cost; rowarg <= 3'd0;
        end else if (m_eng_cost < rowmin) begin
          rowmin <= m_eng_cost; rowarg <= ecnt[2:0];
        end
        if (ecnt[2:0] == 3'd7) begin
          sum  <= sum + 10'(fmin);
          mask <= mask | (8'd1 << farg);
        end
        if (ecnt == 8'd63) ev <= 1'b1;
      end else if (mode == 1) begin
        if (ecnt == 8'd99) ev <= 1'b1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [6:0] beat(input int unsigned kind, input int unsigned k);
    logic [5:0] e;
    e = k[5:0];
    case (kind)
      0:       beat = 7'(k % 100);
      1:       beat = (e[5:3] == e[2:0]) ? 7'd1 : 7'd50;
      2:       beat = 7'h11;
      default: beat = 7'h22;
    endcase
  endfunction

  task automatic load(input int unsigned kind, input bit gaps);
    for (int k = 0; k < 64; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      in_valid = 1'b1;
      in_data  = beat(kind, k);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_m_res(input string tag);
    for (int n = 0; n < 300 && !m_res_valid; n++) step();
    chk(tag, m_res_valid, 1);
  endtask

  task automatic handshake_m();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("hs_res_valid", m_res_valid, 0);
    chk("hs_busy", m_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0; res_ready = 1'b0;
    mode = 2; rd_w = '0; rd_j = '0;
    RST_N = 1'b0;
    #22;
    RST_N = 1'b1;
    step();
    chk("rst_in_ready", m_in_ready, 1);
    chk("rst_busy", m_busy, 0);
    chk("rst_eng_rst", m_eng_rst, 1);
    chk("rst_res_valid", m_res_valid, 0);
    chk("rst_res_mincost", m_res_mincost, 0);
    chk("rst_err", m_err_timeout, 0);
    chk("rst_to_err", t_err_timeout, 0);

    // Reset in the middle of a load.
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = 7'h7F; step();
    end
    in_valid = 1'b0;
    chk("midload_busy", m_busy, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_busy", m_busy, 0);
    chk("midrst_eng_rst", m_eng_rst, 1);
    chk("midrst_res_cycles", m_res_cycles, 0);
    chk("midrst_cost0", m_eng_cost, 0);
    #3 RST_N = 1'b1;
    step();

    // Gapped load, k mod 100; readback via W/J.
    load(0, 1'b1);
    chk("load_in_ready_drop", m_in_ready, 0);
    chk("kick1_eng_rst", m_eng_rst, 1);
    step();
    chk("kick2_eng_rst", m_eng_rst, 1);
    step();
    chk("run_eng_rst", m_eng_rst, 0);
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        rd_w = 3'(w); rd_j = 3'(j);
        #1;
        chk($sformatf("tbl_%0d_%0d", w, j), m_eng_cost, (8 * w + j) % 100);
      end
    end
    step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_run_busy", m_busy, 0);

    // Scanning engine on a diagonal cost matrix.
    mode = 0;
    load(1, 1'b0);
    wait_m_res("diag_wait");
    chk("diag_mincost", m_res_mincost, 8);
    chk("diag_match", m_res_matchcount, 1);
    chk("diag_err", m_err_timeout, 0);
    chk("diag_cycles", m_res_cycles, 64);
    repeat (3) step();
    chk("diag_hold_valid", m_res_valid, 1);
    chk("diag_hold_mincost", m_res_mincost, 8);
    handshake_m();

    // Fixed-latency engine, long hold before consume.
    mode = 1;
    load(2, 1'b0);
    wait_m_res("fix_wait");
    chk("fix_cycles", m_res_cycles, 100);
    chk("fix_mincost", m_res_mincost, 321);
    chk("fix_match", m_res_matchcount, 3);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("fix_hold_valid", m_res_valid, 1);
      chk("fix_hold_mincost", m_res_mincost, 321);
      chk("fix_hold_busy", m_busy, 1);
    end
    handshake_m();

    // Abort during LOAD with a beat offered in the same cycle.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = 7'h22; step();
    end
    in_data = 7'h55; abort = 1'b1;
    #1;
    chk("abort_load_in_ready", m_in_ready, 0);
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_load_busy", m_busy, 0);
    chk("abort_load_eng_rst", m_eng_rst, 1);
    chk("abort_load_res_valid", m_res_valid, 0);
    mode = 2;
    rd_w = 3'd1; rd_j = 3'd2; #1;
    chk("abort_load_entry10", m_eng_cost, 7'h11);
    rd_w = 3'd1; rd_j = 3'd1; #1;
    chk("abort_load_entry9", m_eng_cost, 7'h22);

    // Abort during KICK.
    step();
    load(0, 1'b0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_kick_busy", m_busy, 0);
    step();
    chk("abort_kick_eng_rst", m_eng_rst, 1);

    // Abort in RUN together with eng_valid.
    mode = 1;
    load(0, 1'b0);
    for (int n = 0; n < 300 && !m_eng_valid; n++) step();
    chk("run_wait_eng_valid", m_eng_valid, 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_run_busy2", m_busy, 0);
    chk("abort_run_res_valid", m_res_valid, 0);
    chk("abort_run_eng_rst", m_eng_rst, 1);
    repeat (3) step();
    chk("abort_run_no_result", m_res_valid, 0);

    // Abort in RESULT.
    load(0, 1'b0);
    wait_m_res("res_abort_wait");
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_res_valid", m_res_valid, 0);
    chk("abort_res_busy", m_busy, 0);

    // Timeout instance (TIMEOUT=50), engine never finishes.
    sel = 1'b1;
    load(0, 1'b0);
    step(); step();
    chk("to_run_eng_rst", t_eng_rst, 0);
    repeat (48) step();
    chk("to_not_yet", t_res_valid, 0);
    step();
    chk("to_res_valid", t_res_valid, 1);
    chk("to_mincost", t_res_mincost, 10'h3FF);
    chk("to_match", t_res_matchcount, 0);
    chk("to_err", t_err_timeout, 1);
    chk("to_cycles", t_res_cycles, 49);
    res_ready = 1'b1; step(); res_ready = 1'b0;
    chk("to_hs_valid", t_res_valid, 0);
    chk("to_err_hold", t_err_timeout, 1);
    load(0, 1'b0);
    chk("to_err_before_kick", t_err_timeout, 1);
    step();
    chk("to_err_cleared", t_err_timeout, 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("to_abort_busy", t_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jam_job_ctrl.md
Name: jam_job_ctrl

Overview:
- Job sequencer for the JAM job-assignment search engine.
- Accepts an 8x8 cost matrix from a host stream and holds it in a local table. Serves the engine's combinational W/J cost lookups from that table.
- Releases the engine from reset, waits for its Valid, and captures MinCost/MatchCount plus a run-cycle count.
- Returns the result over a valid/ready handshake, with timeout and abort handling.

Parameters:
- N: 8; workers/jobs per side, fixes the table at N*N entries.
- COST_W: 7; cost entry width.
- TIMEOUT: 24'd400000; RUN cycles allowed before the job is declared failed. Must be greater than 2.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- in_valid  in  1  host cost beat valid
- in_ready  out  1  host cost beat accepted when in_valid&in_ready
- in_data  in  7  cost value; beats are row-major, entry k = row k[5:3], column k[2:0]
- abort  in  1  synchronous job abort
- eng_rst  out  1  active-high synchronous reset to the engine
- eng_W  in  3  engine row (worker) address
- eng_J  in  3  engine column (job) address
- eng_cost  out  7  table[eng_W][eng_J]
- eng_valid  in  1  engine search done
- eng_mincost  in  10  engine MinCost
- eng_matchcount  in  4  engine MatchCount
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_mincost  out  10  captured MinCost
- res_matchcount  out  4  captured MatchCount
- res_cycles  out  24  RUN cycles before eng_valid, saturating at 24'hFFFFFF
- err_timeout  out  1  last job timed out
- busy  out  1  state != IDLE

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE, load index=0, table cleared to 0.
  - res_* =0, res_valid=0, err_timeout=0, busy=0, eng_rst=1, in_ready=1 after reset release.
- eng_cost: purely combinational from the table in every state, zero latency, so the engine sees Cost in the same cycle it drives W/J.
- eng_rst: 1 in every state except RUN. The engine only runs in RUN and cannot re-launch after it reports Valid.
- in_ready = (state==IDLE or LOAD) and not abort.
- States:
  - IDLE: an accepted beat writes entry 0, index becomes 1, go to LOAD.
  - LOAD: an accepted beat writes entry[index] and increments index. Acceptance of entry 63 goes to KICK and resets index to 0. in_valid gaps are allowed with no timeout.
  - KICK: eng_rst held 1 for exactly 2 cycles. Clears res_cycles counter and err_timeout. Then go to RUN.
  - RUN: eng_rst=0. The cycle counter increments each cycle eng_valid is low.
    - eng_valid high: capture eng_mincost, eng_matchcount and counter into res_*, set res_valid=1 next cycle, go to RESULT.
    - Counter reaches TIMEOUT-1 with no eng_valid: res_mincost=10'h3FF, res_matchcount=0, res_cycles=counter, err_timeout=1, res_valid=1, go to RESULT.
  - RESULT: res_* stable while res_valid=1. When res_valid&res_ready, res_valid falls next cycle and the state returns to IDLE. err_timeout holds until the next KICK.
- eng_valid outside RUN is ignored.
- abort, sampled high in any state except IDLE:
  - Next state is IDLE, index=0, res_valid=0, eng_rst=1.
  - Partial table contents remain but are overwritten by the next load.
  - abort in IDLE has no effect.
- Simultaneous events:
  - abort + eng_valid in RUN: abort wins, no result is produced.
  - abort + res_ready in RESULT: IDLE, same as a handshake.
  - abort + in_valid: the beat is not accepted.
- Table writes happen only on accepted beats. There are no reads of partially loaded data during RUN.

Test Plan:
- Reset values: assert RST_N=0 mid-LOAD (after 20 beats) -> outputs return immediately to reset values, eng_rst=1. The next 64-beat load starts again at entry 0.
- Load stream with random in_valid gaps, entry k = k mod 100 -> every table[w][j] read back via eng_W/eng_J equals 8w+j mod 100. in_ready drops after beat 63. eng_rst is 1 for exactly 2 cycles, then 0.
- Real JAM engine attached, cost[w][j] = (w==j)?1:50 -> res_mincost=8, res_matchcount=1, err_timeout=0, res_valid held until res_ready.
- Engine model asserting eng_valid after 100 RUN cycles with mincost 10'd321 and matchcount 4'd3 -> res_cycles=100, res=321/3. With res_ready held low for 10 cycles, the result stays stable and busy=1.
- TIMEOUT=50 with an engine that never asserts valid -> after 49 RUN cycles, res_mincost=10'h3FF, res_matchcount=0, err_timeout=1. The next job clears err_timeout at KICK.
- abort in each of LOAD, KICK, RUN (same cycle as eng_valid) and RESULT -> IDLE next cycle, res_valid=0, eng_rst=1, no result emitted. A beat offered in the abort cycle is not accepted.
